// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vga_timing_pkg
// Brief   : Default 640x480@60Hz timing constants and counter helpers.
// Revision: 1.0
// ============================================================================
package vga_timing_pkg;

    localparam int c_COUNT_W   = 10;
    localparam int c_MAX_TOTAL = 1 << c_COUNT_W;

    localparam int c_DEF_H_VISIBLE = 640;
    localparam int c_DEF_H_FP      = 16;
    localparam int c_DEF_H_SYNC    = 96;
    localparam int c_DEF_H_BP      = 48;
    localparam int c_DEF_V_VISIBLE = 480;
    localparam int c_DEF_V_FP      = 10;
    localparam int c_DEF_V_SYNC    = 2;
    localparam int c_DEF_V_BP      = 33;

    localparam int c_DEF_H_TOTAL      = c_DEF_H_VISIBLE + c_DEF_H_FP + c_DEF_H_SYNC + c_DEF_H_BP;
    localparam int c_DEF_V_TOTAL      = c_DEF_V_VISIBLE + c_DEF_V_FP + c_DEF_V_SYNC + c_DEF_V_BP;
    localparam int c_DEF_H_SYNC_START = c_DEF_H_VISIBLE + c_DEF_H_FP;
    localparam int c_DEF_H_SYNC_END   = c_DEF_H_SYNC_START + c_DEF_H_SYNC;
    localparam int c_DEF_V_SYNC_START = c_DEF_V_VISIBLE + c_DEF_V_FP;
    localparam int c_DEF_V_SYNC_END   = c_DEF_V_SYNC_START + c_DEF_V_SYNC;

    typedef logic [c_COUNT_W-1:0] count_t;

    // Widened to int so a window ending exactly at 1024 still decodes correctly.
    function automatic logic in_window(input count_t val, input int lo, input int hi);
        return (int'(val) >= lo) && (int'(val) < hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_pixel_tick.sv
`default_nettype none
// ============================================================================
// Module  : vga_pixel_tick
// Brief   : Divides clk by CLK_DIV into a one-cycle pixel-rate tick.
// Revision: 1.0
// ============================================================================
module vga_pixel_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int c_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLK_DIV - 1);

    logic [c_CNT_W-1:0] div_q;
    logic [c_CNT_W-1:0] div_d;

    assign tick_o = (div_q == c_CNT_LAST);

    always_comb begin
        div_d = div_q + 1'b1;
        if (tick_o) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module  : vga_timing_gen
// Brief   : Raster timing generator: pixel/line counters, syncs, bright flag.
// Revision: 1.0
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = c_DEF_H_VISIBLE,
    parameter int H_FP      = c_DEF_H_FP,
    parameter int H_SYNC    = c_DEF_H_SYNC,
    parameter int H_BP      = c_DEF_H_BP,
    parameter int V_VISIBLE = c_DEF_V_VISIBLE,
    parameter int V_FP      = c_DEF_V_FP,
    parameter int V_SYNC    = c_DEF_V_SYNC,
    parameter int V_BP      = c_DEF_V_BP
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 hSync,
    output logic                 vSync,
    output logic                 bright,
    output logic [c_COUNT_W-1:0] hCount,
    output logic [c_COUNT_W-1:0] vCount,
    output logic                 pixel_en,
    output logic                 frame_start
);

    localparam int c_H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int c_H_SYNC_START = H_VISIBLE + H_FP;
    localparam int c_H_SYNC_END   = c_H_SYNC_START + H_SYNC;
    localparam int c_V_SYNC_START = V_VISIBLE + V_FP;
    localparam int c_V_SYNC_END   = c_V_SYNC_START + V_SYNC;
    localparam count_t c_H_LAST   = count_t'(c_H_TOTAL - 1);
    localparam count_t c_V_LAST   = count_t'(c_V_TOTAL - 1);

    generate
        if ((CLK_DIV < 1) || (c_H_TOTAL < 1) || (c_V_TOTAL < 1) ||
            (c_H_TOTAL > c_MAX_TOTAL) || (c_V_TOTAL > c_MAX_TOTAL)) begin : g_bad_params
            $error("vga_timing_gen: CLK_DIV must be >= 1 and totals must be 1..1024");
        end
    endgenerate

    logic   tick;
    count_t h_q, h_d;
    count_t v_q, v_d;
    logic   frame_wrap;
    logic   hsync_q, vsync_q, bright_q, pixel_en_q, frame_start_q;

    vga_pixel_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (tick)
    );

    always_comb begin
        h_d        = h_q;
        v_d        = v_q;
        frame_wrap = 1'b0;
        if (tick) begin
            if (h_q == c_H_LAST) begin
                h_d = '0;
                if (v_q == c_V_LAST) begin
                    v_d        = '0;
                    frame_wrap = 1'b1;
                end else begin
                    v_d = v_q + 1'b1;
                end
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // Decoding from the next-state counts keeps syncs/bright aligned with the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q           <= '0;
            v_q           <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            bright_q      <= 1'b0;
            pixel_en_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= ~in_window(h_d, c_H_SYNC_START, c_H_SYNC_END);
            vsync_q       <= ~in_window(v_d, c_V_SYNC_START, c_V_SYNC_END);
            bright_q      <= in_window(h_d, 0, H_VISIBLE) & in_window(v_d, 0, V_VISIBLE);
            pixel_en_q    <= tick;
            frame_start_q <= frame_wrap;
        end
    end

    assign hCount      = h_q;
    assign vCount      = v_q;
    assign hSync       = hsync_q;
    assign vSync       = vsync_q;
    assign bright      = bright_q;
    assign pixel_en    = pixel_en_q;
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_timing_gen
// Brief   : Scoreboard bench for vga_timing_gen (default, CLK_DIV=1, small raster).
// Revision: 1.0
// ============================================================================
module tb_vga_timing_gen;

    typedef struct {
        int cyc;
        int h;
        int v;
        bit hs;
        bit vs;
        bit br;
        bit fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst2_n = 1'b0;
    logic rst1_n = 1'b0;
    logic rsts_n = 1'b0;

    logic       hs2, vs2, br2, pe2, fs2;
    logic [9:0] hc2, vc2;
    logic       hs1, vs1, br1, pe1, fs1;
    logic [9:0] hc1, vc1;
    logic       hss, vss, brs, pes, fss;
    logic [9:0] hcs, vcs;

    int tests = 0;
    int fails = 0;
    int cyc2, cyc1, cycs;

    exp_t q2[$];
    exp_t q1[$];
    exp_t qs[$];

    always #5 clk = ~clk;

    vga_timing_gen #(.CLK_DIV(2)) u_dut2 (
        .clk(clk), .rst_n(rst2_n), .hSync(hs2), .vSync(vs2), .bright(br2),
        .hCount(hc2), .vCount(vc2), .pixel_en(pe2), .frame_start(fs2)
    );

    vga_timing_gen #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst1_n), .hSync(hs1), .vSync(vs1), .bright(br1),
        .hCount(hc1), .vCount(vc1), .pixel_en(pe1), .frame_start(fs1)
    );

    // Small raster: H_TOTAL=15 (sync 10..12), V_TOTAL=8 (sync 5..6), frame = 240 clks.
    vga_timing_gen #(
        .CLK_DIV(2), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_duts (
        .clk(clk), .rst_n(rsts_n), .hSync(hss), .vSync(vss), .bright(brs),
        .hCount(hcs), .vCount(vcs), .pixel_en(pes), .frame_start(fss)
    );

    always @(posedge clk or negedge rst2_n) if (!rst2_n) cyc2 <= 0; else cyc2 <= cyc2 + 1;
    always @(posedge clk or negedge rst1_n) if (!rst1_n) cyc1 <= 0; else cyc1 <= cyc1 + 1;
    always @(posedge clk or negedge rsts_n) if (!rsts_n) cycs <= 0; else cycs <= cycs + 1;

    function automatic exp_t mk(input int cyc, input int h, input int v,
                                input bit hs, input bit vs, input bit br, input bit fs);
        exp_t e;
        e.cyc = cyc; e.h = h; e.v = v; e.hs = hs; e.vs = vs; e.br = br; e.fs = fs;
        return e;
    endfunction

    function automatic exp_t model_small(input int k);
        int pos, h, v;
        pos = k % 120;
        h   = pos % 15;
        v   = pos / 15;
        return mk(2 * k, h, v, !(h >= 10 && h < 13), !(v >= 5 && v < 7),
                  (h < 8) && (v < 4), pos == 0);
    endfunction

    task automatic check_cycle(input string nm, input int div, input int cyc,
                               input logic pe, input logic fs, input bit have, input exp_t e,
                               input logic [9:0] h, input logic [9:0] v,
                               input logic hs, input logic vs, input logic br);
        logic exp_pe;
        exp_pe = (cyc > 0) && (cyc % div == 0);
        tests++;
        if (pe !== exp_pe) begin
            fails++;
            $display("FAIL %s pixel_en cyc=%0d: got %b expected %b", nm, cyc, pe, exp_pe);
        end
        tests++;
        if ((br === 1'b1 && (hs !== 1'b1 || vs !== 1'b1)) || (fs === 1'b1 && pe !== 1'b1)) begin
            fails++;
            $display("FAIL %s strobe_consistency cyc=%0d: got br=%b hs=%b vs=%b fs=%b pe=%b expected no bright in sync and fs only with pe",
                     nm, cyc, br, hs, vs, fs, pe);
        end
        if (have) begin
            tests++;
            if (cyc != e.cyc || int'(h) != e.h || int'(v) != e.v || hs !== e.hs ||
                vs !== e.vs || br !== e.br || fs !== e.fs) begin
                fails++;
                $display("FAIL %s tick: got cyc=%0d h=%0d v=%0d hs=%b vs=%b br=%b fs=%b expected cyc=%0d h=%0d v=%0d hs=%b vs=%b br=%b fs=%b",
                         nm, cyc, h, v, hs, vs, br, fs, e.cyc, e.h, e.v, e.hs, e.vs, e.br, e.fs);
            end
        end
    endtask

    task automatic mon2();
        exp_t e;
        bit   have;
        have = 1'b0;
        e    = mk(0, 0, 0, 1, 1, 0, 0);
        if (pe2 === 1'b1 && q2.size() > 0 && q2[0].cyc <= cyc2) begin
            e = q2.pop_front();
            have = 1'b1;
        end
        check_cycle("div2", 2, cyc2, pe2, fs2, have, e, hc2, vc2, hs2, vs2, br2);
    endtask

    task automatic mon1();
        exp_t e;
        bit   have;
        have = 1'b0;
        e    = mk(0, 0, 0, 1, 1, 0, 0);
        if (pe1 === 1'b1 && q1.size() > 0 && q1[0].cyc <= cyc1) begin
            e = q1.pop_front();
            have = 1'b1;
        end
        check_cycle("div1", 1, cyc1, pe1, fs1, have, e, hc1, vc1, hs1, vs1, br1);
    endtask

    task automatic mons();
        exp_t e;
        bit   have;
        have = 1'b0;
        e    = mk(0, 0, 0, 1, 1, 0, 0);
        if (pes === 1'b1 && qs.size() > 0 && qs[0].cyc <= cycs) begin
            e = qs.pop_front();
            have = 1'b1;
        end
        check_cycle("small", 2, cycs, pes, fss, have, e, hcs, vcs, hss, vss, brs);
    endtask

    always @(negedge clk) if (rst2_n) mon2();
    always @(negedge clk) if (rst1_n) mon1();
    always @(negedge clk) if (rsts_n) mons();

    task automatic check_rst(input string nm, input logic [9:0] h, input logic [9:0] v,
                             input logic hs, input logic vs, input logic br,
                             input logic pe, input logic fs);
        tests++;
        if (h !== 10'd0 || v !== 10'd0 || hs !== 1'b1 || vs !== 1'b1 ||
            br !== 1'b0 || pe !== 1'b0 || fs !== 1'b0) begin
            fails++;
            $display("FAIL %s reset_state: got h=%0d v=%0d hs=%b vs=%b br=%b pe=%b fs=%b expected h=0 v=0 hs=1 vs=1 br=0 pe=0 fs=0",
                     nm, h, v, hs, vs, br, pe, fs);
        end
    endtask

    task automatic wait_drain(input string nm, input int bound);
        int n;
        n = 0;
        while ((q2.size() + q1.size() + qs.size()) > 0 && n < bound) begin
            @(posedge clk);
            n++;
        end
        tests++;
        if ((q2.size() + q1.size() + qs.size()) > 0) begin
            fails++;
            $display("FAIL %s drain: got %0d/%0d/%0d pending expected 0/0/0",
                     nm, q2.size(), q1.size(), qs.size());
            q2.delete();
            q1.delete();
            qs.delete();
        end
    endtask

    initial begin
        int n;

        repeat (3) @(posedge clk);
        #1;
        check_rst("div2_init", hc2, vc2, hs2, vs2, br2, pe2, fs2);
        check_rst("div1_init", hc1, vc1, hs1, vs1, br1, pe1, fs1);
        check_rst("small_init", hcs, vcs, hss, vss, brs, pes, fss);

        @(posedge clk);
        #2;
        rst2_n = 1'b1;
        rst1_n = 1'b1;
        rsts_n = 1'b1;

        q2.push_back(mk(2,    1,   0, 1, 1, 1, 0));
        q2.push_back(mk(4,    2,   0, 1, 1, 1, 0));
        q2.push_back(mk(6,    3,   0, 1, 1, 1, 0));
        q2.push_back(mk(1278, 639, 0, 1, 1, 1, 0));
        q2.push_back(mk(1280, 640, 0, 1, 1, 0, 0));
        q2.push_back(mk(1310, 655, 0, 1, 1, 0, 0));
        q2.push_back(mk(1312, 656, 0, 0, 1, 0, 0));
        q2.push_back(mk(1502, 751, 0, 0, 1, 0, 0));
        q2.push_back(mk(1504, 752, 0, 1, 1, 0, 0));
        q2.push_back(mk(1598, 799, 0, 1, 1, 0, 0));
        q2.push_back(mk(1600, 0,   1, 1, 1, 1, 0));
        q2.push_back(mk(1602, 1,   1, 1, 1, 1, 0));

        q1.push_back(mk(1,    1,   0, 1, 1, 1, 0));
        q1.push_back(mk(2,    2,   0, 1, 1, 1, 0));
        q1.push_back(mk(3,    3,   0, 1, 1, 1, 0));
        q1.push_back(mk(656,  656, 0, 0, 1, 0, 0));
        q1.push_back(mk(799,  799, 0, 1, 1, 0, 0));
        q1.push_back(mk(800,  0,   1, 1, 1, 1, 0));
        q1.push_back(mk(801,  1,   1, 1, 1, 1, 0));
        q1.push_back(mk(1600, 0,   2, 1, 1, 1, 0));

        for (int k = 1; k <= 250; k++) qs.push_back(model_small(k));

        wait_drain("run1", 2000);

        // Mid-line async reset on the default build, between ticks.
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(hc2 == 10'd300 && vc2 == 10'd1) && n < 3000);
        tests++;
        if (!(hc2 == 10'd300 && vc2 == 10'd1)) begin
            fails++;
            $display("FAIL div2_reach_300 timeout: got h=%0d v=%0d expected h=300 v=1", hc2, vc2);
        end
        #1;
        rst2_n = 1'b0;
        #1;
        check_rst("div2_async", hc2, vc2, hs2, vs2, br2, pe2, fs2);
        repeat (3) @(posedge clk);
        #2;
        rst2_n = 1'b1;
        q2.push_back(mk(2,    1,   0, 1, 1, 1, 0));
        q2.push_back(mk(4,    2,   0, 1, 1, 1, 0));
        q2.push_back(mk(1280, 640, 0, 1, 1, 0, 0));
        wait_drain("div2_restart", 2000);

        // Mid-frame async reset on the small raster while both syncs are active.
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(hcs == 10'd10 && vcs == 10'd5) && n < 600);
        tests++;
        if (!(hcs == 10'd10 && vcs == 10'd5 && hss === 1'b0 && vss === 1'b0)) begin
            fails++;
            $display("FAIL small_reach_10_5: got h=%0d v=%0d hs=%b vs=%b expected h=10 v=5 hs=0 vs=0",
                     hcs, vcs, hss, vss);
        end
        #1;
        rsts_n = 1'b0;
        #1;
        check_rst("small_async", hcs, vcs, hss, vss, brs, pes, fss);
        repeat (3) @(posedge clk);
        #2;
        rsts_n = 1'b1;
        for (int k = 1; k <= 130; k++) qs.push_back(model_small(k));
        wait_drain("small_restart", 600);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
